// File: rtl/counter_write_sched.sv
// counter_write_sched: round-robin scheduler sharing the 8253-style timer programming port.
// Define COUNTER_AUTO_RELOAD_EN to re-issue a channel's last written count when its output rises.
module counter_write_sched #(
    parameter int N_REQ = 2,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [2*N_REQ-1:0]    req_ch,
    input  logic [32*N_REQ-1:0]   req_val,
    output logic [N_REQ-1:0]      ack,
    input  logic [2:0]            reload_en,
    input  logic                  counter0_OUT,
    input  logic                  counter1_OUT,
    input  logic                  counter2_OUT,
    output logic                  counter_we,
    output logic [1:0]            counter_ch,
    output logic [31:0]           counter_val,
    output logic [2:0]            reload_pend,
    output logic                  busy,
    output logic [1:0]            state_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [1:0]    state_q, state_d;
    logic [3:0]    gap_q, gap_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          from_req_q, from_req_d;
    logic [1:0]    ch_q, ch_d;
    logic [31:0]   val_q, val_d;

    logic          issue;
    logic          rel_any;
    logic [1:0]    rel_ch;
    logic [31:0]   rel_val;
    logic          win_any;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic [N_REQ-1:0] one_hot;

    assign issue = (state_q == S_ISSUE);

    // Round-robin search begins just after the last granted requester.
    always_comb begin
        win_any = 1'b0;
        win_idx = rr_q;
        cand    = rr_q;
        for (int j = 1; j <= N_REQ; j++) begin
            cand = IW'((int'(rr_q) + j) % N_REQ);
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        rr_d       = rr_q;
        idx_d      = idx_q;
        from_req_d = from_req_q;
        ch_d       = ch_q;
        val_d      = val_q;
        case (state_q)
            S_IDLE: begin
                if (rel_any) begin
                    state_d    = S_ISSUE;
                    from_req_d = 1'b0;
                    ch_d       = rel_ch;
                    val_d      = rel_val;
                end else if (win_any) begin
                    state_d    = S_ISSUE;
                    from_req_d = 1'b1;
                    idx_d      = win_idx;
                    rr_d       = win_idx;
                    ch_d       = req_ch[2*int'(win_idx) +: 2];
                    val_d      = req_val[32*int'(win_idx) +: 32];
                end
            end
            S_ISSUE: begin
                if (GAP == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    gap_d   = GAP_M1;
                end
            end
            S_WAIT: begin
                if (gap_q == 4'd0) state_d = S_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gap_q      <= 4'd0;
            rr_q       <= IW'(N_REQ - 1);
            idx_q      <= '0;
            from_req_q <= 1'b0;
            ch_q       <= 2'd0;
            val_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            from_req_q <= from_req_d;
            ch_q       <= ch_d;
            val_q      <= val_d;
        end
    end

    always_comb begin
        one_hot        = '0;
        one_hot[idx_q] = 1'b1;
    end

    // A reset landing in the issue cycle retracts the strobe and ack immediately.
    assign ack         = (issue && from_req_q && !rst) ? one_hot : '0;
    assign counter_we  = issue && !rst;
    assign counter_ch  = ch_q;
    assign counter_val = val_q;
    assign busy        = (state_q != S_IDLE);
    assign state_o     = state_q;

`ifdef COUNTER_AUTO_RELOAD_EN
    logic [2:0]  out_q, pend_q, shv_q, rise, clr;
    logic [31:0] shadow_q [3];

    assign rise = {counter2_OUT, counter1_OUT, counter0_OUT} & ~out_q & reload_en & shv_q;
    assign clr  = (issue && !from_req_q) ? (3'b001 << ch_q) : 3'b000;

    // A new edge wins over the clear of the reload that is issuing now.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= 3'b000;
            pend_q <= 3'b000;
            shv_q  <= 3'b000;
            for (int c = 0; c < 3; c++) shadow_q[c] <= 32'd0;
        end else begin
            out_q  <= {counter2_OUT, counter1_OUT, counter0_OUT};
            pend_q <= (pend_q & ~clr) | rise;
            if (issue && from_req_q) begin
                for (int c = 0; c < 3; c++) begin
                    if (ch_q == 2'(c)) begin
                        shadow_q[c] <= val_q;
                        shv_q[c]    <= 1'b1;
                    end
                end
            end
        end
    end

    assign rel_any     = |pend_q;
    assign rel_ch      = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
    assign rel_val     = pend_q[0] ? shadow_q[0] : (pend_q[1] ? shadow_q[1] : shadow_q[2]);
    assign reload_pend = pend_q;
`else
    logic unused_reload_in;
    assign unused_reload_in = ^{reload_en, counter0_OUT, counter1_OUT, counter2_OUT};
    assign rel_any     = 1'b0;
    assign rel_ch      = 2'd0;
    assign rel_val     = 32'd0;
    assign reload_pend = 3'b000;
`endif

endmodule

// File: tb/tb_counter_write_sched.sv
// tb_counter_write_sched: randomized bench driving three schedulers (GAP 0, 1, 3) side by side.
// A cycle-numbered scheduling model predicts every output; reload behaviour follows COUNTER_AUTO_RELOAD_EN.
module tb_counter_write_sched;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_a     [NI];
    logic [3:0]  req_ch_a  [NI];
    logic [63:0] req_val_a [NI];
    logic [1:0]  ack_a     [NI];
    logic        we_a      [NI];
    logic [1:0]  ch_a      [NI];
    logic [31:0] val_a     [NI];
    logic [2:0]  pend_a    [NI];
    logic        busy_a    [NI];
    logic [1:0]  state_a   [NI];
    logic [2:0]  reload_en_v;
    logic [2:0]  outs_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        counter_write_sched #(
            .N_REQ(2),
            .GAP  (g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req         (req_a[g]),
            .req_ch      (req_ch_a[g]),
            .req_val     (req_val_a[g]),
            .ack         (ack_a[g]),
            .reload_en   (reload_en_v),
            .counter0_OUT(outs_v[0]),
            .counter1_OUT(outs_v[1]),
            .counter2_OUT(outs_v[2]),
            .counter_we  (we_a[g]),
            .counter_ch  (ch_a[g]),
            .counter_val (val_a[g]),
            .reload_pend (pend_a[g]),
            .busy        (busy_a[g]),
            .state_o     (state_a[g])
        );
    end

    // Model state: each write is a record {is_reload, ack, ch, val} due in a known cycle.
    logic [36:0] exp_q    [NI][$];
    int          free_c   [NI];
    int          issue_c  [NI];
    int          rr_last  [NI];
    logic [1:0]  last_ch  [NI];
    logic [31:0] last_val [NI];
    logic [2:0]  pend_m   [NI];
    logic [2:0]  shv_m    [NI];
    logic [31:0] shadow_m [NI][3];
    logic        act      [NI][2];
    logic [1:0]  rch      [NI][2];
    logic [31:0] rval     [NI][2];
    logic [2:0]  out_prev;
    logic        rst_pend;
    int          cyc;
    int          n_chk;
    int          n_err;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            free_c[k]   = cyc;
            issue_c[k]  = -1;
            rr_last[k]  = 1;
            last_ch[k]  = 2'd0;
            last_val[k] = 32'd0;
            pend_m[k]   = 3'b000;
            shv_m[k]    = 3'b000;
            exp_q[k].delete();
            for (int c = 0; c < 3; c++) shadow_m[k][c] = 32'd0;
        end
        out_prev = 3'b000;
    endtask

    task automatic new_req(input int k, input int i);
        act[k][i]  = 1'b1;
        rch[k][i]  = 2'($urandom_range(0, 3));
        rval[k][i] = $urandom;
    endtask

    // mode 0: only injected requests, 1: both requesters always asking, 2: random traffic.
    task automatic run_cycle(input int mode, input bit inject, input bit rst_try);
        logic        issuing [NI];
        logic        is_rel  [NI];
        logic [1:0]  ack_e   [NI];
        logic [36:0] e;
        logic [2:0]  pend_old, set, clr;
        logic [1:0]  reqv;
        int          w;
        if (rst_pend) begin
            rst      = 1'b0;
            rst_pend = 1'b0;
            model_reset();
        end
        for (int k = 0; k < NI; k++) begin
            issuing[k] = (cyc == issue_c[k]);
            is_rel[k]  = 1'b0;
            ack_e[k]   = 2'b00;
            if (issuing[k] && exp_q[k].size() > 0) begin
                e           = exp_q[k].pop_front();
                is_rel[k]   = e[36];
                ack_e[k]    = e[35:34];
                last_ch[k]  = e[33:32];
                last_val[k] = e[31:0];
            end
            check($sformatf("we.g%0d", k),   64'(we_a[k]),   64'(issuing[k]));
            check($sformatf("ack.g%0d", k),  64'(ack_a[k]),  64'(ack_e[k]));
            check($sformatf("ch.g%0d", k),   64'(ch_a[k]),   64'(last_ch[k]));
            check($sformatf("val.g%0d", k),  64'(val_a[k]),  64'(last_val[k]));
            check($sformatf("busy.g%0d", k), 64'(busy_a[k]), 64'(cyc < free_c[k]));
            check($sformatf("pend.g%0d", k), 64'(pend_a[k]), 64'(pend_m[k]));
        end
        if (rst_try && cyc == issue_c[1]) begin
            rst      = 1'b1;
            rst_pend = 1'b1;
            #1;
            for (int k = 0; k < NI; k++) begin
                check($sformatf("ack_abandon.g%0d", k), 64'(ack_a[k]), 64'd0);
                check($sformatf("we_abandon.g%0d", k),  64'(we_a[k]),  64'd0);
            end
            return;
        end
        if (mode == 2) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) outs_v[b] = ~outs_v[b];
            if ($urandom_range(0, 31) == 0) reload_en_v = 3'($urandom_range(0, 7));
        end
        for (int k = 0; k < NI; k++) begin
            pend_old = pend_m[k];
            for (int i = 0; i < 2; i++) begin
                if (act[k][i] && issuing[k] && ack_e[k][i]) begin
                    act[k][i] = 1'b0;
                    if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 0)) new_req(k, i);
                end else if (act[k][i] && mode == 2 && $urandom_range(0, 39) == 0) begin
                    act[k][i] = 1'b0;
                end else if (!act[k][i] && (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0))) begin
                    new_req(k, i);
                end
            end
            if (inject) begin
                act[k][0]  = 1'b1;
                rch[k][0]  = 2'd1;
                rval[k][0] = 32'h0000_1234;
            end
            req_a[k]     = {act[k][1], act[k][0]};
            req_ch_a[k]  = {rch[k][1], rch[k][0]};
            req_val_a[k] = {rval[k][1], rval[k][0]};
`ifdef COUNTER_AUTO_RELOAD_EN
            set = outs_v & ~out_prev & reload_en_v & shv_m[k];
`else
            set = 3'b000;
`endif
            clr = (issuing[k] && is_rel[k]) ? (3'b001 << last_ch[k]) : 3'b000;
            pend_m[k] = (pend_m[k] & ~clr) | set;
            if (issuing[k] && !is_rel[k] && last_ch[k] != 2'd3) begin
                shadow_m[k][int'(last_ch[k])] = last_val[k];
                shv_m[k][int'(last_ch[k])]    = 1'b1;
            end
            reqv = req_a[k];
            if (cyc >= free_c[k] && (pend_old != 3'b000 || reqv != 2'b00)) begin
                if (pend_old != 3'b000) begin
                    w = pend_old[0] ? 0 : (pend_old[1] ? 1 : 2);
                    exp_q[k].push_back({1'b1, 2'b00, 2'(w), shadow_m[k][w]});
                end else begin
                    w = (rr_last[k] + 1) % 2;
                    if (!reqv[w]) w = (w + 1) % 2;
                    rr_last[k] = w;
                    exp_q[k].push_back({1'b0, 2'(1 << w), rch[k][w], rval[k][w]});
                end
                issue_c[k] = cyc + 1;
                free_c[k]  = cyc + 2 + gap_of(k);
            end
        end
        out_prev = outs_v;
    endtask

    task automatic tick(input int mode, input bit inject, input bit rst_try);
        @(negedge clk);
        cyc++;
        run_cycle(mode, inject, rst_try);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        bit fired;
        n_chk       = 0;
        n_err       = 0;
        cyc         = 0;
        rst         = 1'b1;
        rst_pend    = 1'b1;
        outs_v      = 3'b000;
        reload_en_v = 3'b111;
        out_prev    = 3'b000;
        for (int k = 0; k < NI; k++) begin
            req_a[k]     = 2'b00;
            req_ch_a[k]  = 4'h0;
            req_val_a[k] = 64'd0;
            for (int i = 0; i < 2; i++) begin
                act[k][i]  = 1'b0;
                rch[k][i]  = 2'd0;
                rval[k][i] = 32'd0;
            end
        end
        repeat (3) @(negedge clk);

        tick(0, 1'b1, 1'b0);
        repeat (8) tick(0, 1'b0, 1'b0);
        repeat (40) tick(1, 1'b0, 1'b0);
        repeat (1500) tick(2, 1'b0, 1'b0);

        fired = 1'b0;
        for (int n = 0; n < 200 && !fired; n++) begin
            tick(2, 1'b0, 1'b1);
            fired = rst_pend;
        end
        check("rst_window", 64'(fired), 64'd1);
        repeat (300) tick(2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/counter_write_sched.md
# counter_write_sched

Write-port scheduler for the three-channel 8253-style timer block. Shares the timer's single programming port (`counter_we` / `counter_ch` / `counter_val`) between several bus-side requesters using round-robin arbitration. Spaces successive writes by a programmable gap. Optionally re-issues a stored initial count when a channel's output rises, giving periodic game-tick timers without CPU involvement.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, 1..4.
- `GAP`, 1: idle cycles after each issued write, 0..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: per-requester write request, held until acked.
- `req_ch`  in  2*N_REQ: channel for requester i at bits [2i+1:2i]. 0..2 are count channels; 3 is the control word.
- `req_val`  in  32*N_REQ: value for requester i at bits [32i+31:32i].
- `ack`  out  N_REQ: one-cycle pulse; the request was issued this cycle.
- `reload_en`  in  3: per-channel auto-reload enable.
- `counter0_OUT`, `counter1_OUT`, `counter2_OUT`  in  1 each: channel outputs from the timer.
- `counter_we`  out  1: write strobe to the timer.
- `counter_ch`  out  2: channel to the timer.
- `counter_val`  out  32: value to the timer.
- `reload_pend`  out  3: pending auto-reload flags.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE when any pending reload or any `req` bit is set. The winner is registered on the same edge.
- ISSUE lasts exactly one cycle, with `counter_we`=1.
  - Goes to WAIT if GAP>0.
  - Goes to IDLE if GAP=0.
- WAIT counts GAP cycles, then goes to IDLE.
- Priority:
  - Pending reloads beat requesters; among reloads, channel 0 first.
  - Requesters are round-robin: search starts at (last granted + 1) mod N_REQ. The pointer updates only on requester grants.
- Requester grant: `ack[i]`=1 during ISSUE; `counter_ch`/`counter_val` come from requester i.
- Reload grant: `counter_ch`=x, `counter_val`=shadow[x]; no `ack` pulse.
- `counter_ch`/`counter_val` hold their last issued value outside ISSUE.
- Requests dropped before ack are simply not served.
- A requester must not change `req_ch`/`req_val` while `req` is high.

## Timing
- Reset values:
  - Outputs: `counter_we`=0, `counter_ch`=0, `counter_val`=0, `ack`=0, `busy`=0, `reload_pend`=0.
  - Internals: round-robin pointer set so requester 0 wins first; state IDLE; shadows invalid.
- Latency: `req` seen in IDLE at cycle t → `counter_we`/`ack` high in cycle t+1.
- Throughput: one write every GAP+2 cycles when requests are back-to-back.
- Reset asserted in ISSUE or WAIT: the write in flight is abandoned, no `ack` is issued, and next cycle is IDLE.
- Requests arriving in ISSUE or WAIT wait for the next IDLE. No request is lost while `req` is held.

## Configuration
- Macro: `COUNTER_AUTO_RELOAD_EN`.
- When defined:
  - Each requester write to channel x (0..2) updates shadow[x] and marks it valid.
  - A rising edge of `counterX_OUT` (compared against a registered copy) sets `reload_pend[x]`, provided `reload_en[x]` and shadow[x] is valid.
  - `reload_pend[x]` clears when its reload is issued.
  - An edge in the same cycle as the clear keeps it set.
  - Repeated edges while pending merge into one reload.
  - Channel 3 is never reloaded.
- When undefined: there are no shadows or edge detectors, `reload_pend` is tied to 0, `reload_en` and the `counterX_OUT` inputs are ignored, and only requesters are scheduled.

## Test plan
- Single request: N_REQ=2, GAP=1, after reset req0 ch=1 val=0x0000_1234 → one cycle later `counter_we`=1, `counter_ch`=1, `counter_val`=0x1234, `ack`=01; `busy` 1 for 2 cycles; IDLE on the third.
- Round robin: req=11 held continuously, GAP=0 → grants alternate 0,1,0,1, one `ack` every 2 cycles, never both bits set.
- GAP=3: req0 held for two writes → the `counter_we` pulses are exactly 5 cycles apart.
- Reset mid-write: assert `rst` in the ISSUE cycle → no `ack`, `counter_we`=0 next cycle, all outputs at reset values.
- Auto-reload (macro on): req0 ch=2 val=100, `reload_en`=100, rising edge on `counter2_OUT` → `reload_pend`=100, then one cycle later a write with ch=2, val=100 and no `ack`; a simultaneous req1 is served after it.
- Macro off, same stimulus → no reload write; `reload_pend` stays 000.
